bound_flasher_monitor: RTL and testbench

Passive checker on the 16-bit LED bus of the bound flasher. Each cycle it samples `led` and `flick`, decodes the lit count, tracks which phase of the flasher sequence is running, reports kick-backs and completed cycles, and flags any protocol violation. It sits beside the flasher in the board top and the system bench, and has no influence on the flasher.

---
 rtl/bfm_pkg.sv | 38 +++
 rtl/bound_flasher_monitor_thermo_decode.sv | 25 ++
 rtl/bound_flasher_monitor.sv | 186 ++++++++++++++++++
 tb/tb_bound_flasher_monitor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bfm_pkg.sv
// Shared types and constants for the bound flasher LED-bus monitor.
package bfm_pkg;

    localparam int unsigned LED_W = 16;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [3:0] {
        PH_IDLE   = 4'd0,
        PH_UP1    = 4'd1,
        PH_DN1    = 4'd2,
        PH_UP2    = 4'd3,
        PH_DN2    = 4'd4,
        PH_UP3    = 4'd5,
        PH_DN3    = 4'd6,
        PH_FLASH  = 4'd7,
        PH_KICK2  = 4'd8,
        PH_KICK3  = 4'd9,
        PH_RESYNC = 4'd15
    } phase_e;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_THERMO    = 3'd1;
    localparam logic [2:0] ERR_STEP      = 3'd2;
    localparam logic [2:0] ERR_REVERSE   = 3'd3;
    localparam logic [2:0] ERR_OVERSHOOT = 3'd4;
    localparam logic [2:0] ERR_STALL     = 3'd5;

    localparam logic [CNT_W-1:0] LIM_UP1 = 5'd6;
    localparam logic [CNT_W-1:0] LIM_UP2 = 5'd11;
    localparam logic [CNT_W-1:0] LIM_DN2 = 5'd5;
    localparam logic [CNT_W-1:0] LIM_UP3 = 5'd16;

    localparam logic [CNT_W-1:0] KICK_LO = 5'd5;
    localparam logic [CNT_W-1:0] KICK_HI = 5'd10;

    localparam logic [LED_W-1:0] ALL_ON = 16'hFFFF;

endpackage

// File: rtl/bound_flasher_monitor_thermo_decode.sv
// Thermometer decoder: counts the contiguous ones from bit 0 and flags
// any value that is not a clean low-filled thermometer code.
module thermo_decode
    import bfm_pkg::*;
(
    input  logic [LED_W-1:0] led,
    output logic             valid,
    output logic [CNT_W-1:0] n
);

    // Count the run of ones starting at bit 0.
    always_comb begin
        logic run;
        n   = '0;
        run = 1'b1;
        for (int i = 0; i < int'(LED_W); i++) begin
            if (!led[i]) run = 1'b0;
            if (run) n = n + CNT_W'(1);
        end
    end

    // A thermometer value plus one is a power of two (or wraps to zero).
    assign valid = (((led + LED_W'(1)) & led) == '0);

endmodule

// File: rtl/bound_flasher_monitor.sv
// Passive protocol monitor for the bound flasher LED bus.
// Optional stall checking is enabled with the BFM_STALL_CHECK_EN macro.
module bound_flasher_monitor
    import bfm_pkg::*;
#(
    parameter int unsigned STALL_MAX = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [LED_W-1:0] led,
    input  logic             flick,
    output logic [3:0]       phase,
    output logic [CNT_W-1:0] lit_count,
    output logic             kick_pulse,
    output logic             done_pulse,
    output logic             error,
    output logic [2:0]       err_code
);

    phase_e           phase_q, phase_nxt;
    logic [CNT_W-1:0] p_q;
    logic             flick_q;
    logic             kick_hi_q, kick_hi_nxt;
    logic             valid;
    logic [CNT_W-1:0] n;
    logic             up, dn, hold, big, stall_hit;
    logic             kick_ok, kick_c, done_c;
    logic [2:0]       code;

    thermo_decode u_decode (
        .led   (led),
        .valid (valid),
        .n     (n)
    );

    assign up   = (n == p_q + CNT_W'(1));
    assign dn   = (n + CNT_W'(1) == p_q);
    assign hold = (n == p_q);
    assign big  = !(up || dn || hold);
    // A fall from a kick count is only legal with the paired flick sample high.
    assign kick_ok = dn && flick_q && ((p_q == KICK_LO) || (p_q == KICK_HI));

`ifdef BFM_STALL_CHECK_EN
    localparam int unsigned SC_W = $clog2(STALL_MAX + 1);
    logic [SC_W-1:0] stall_cnt;

    // Saturating count of consecutive non-zero holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (hold && (n != '0)) begin
            if (stall_cnt != SC_W'(STALL_MAX)) stall_cnt <= stall_cnt + SC_W'(1);
        end else begin
            stall_cnt <= '0;
        end
    end

    assign stall_hit = hold && (n != '0) && (stall_cnt >= SC_W'(STALL_MAX - 1));
`else
    wire unused_stall_max = |32'(STALL_MAX);
    assign stall_hit = 1'b0;
`endif

    // Classify the current sample against the phase rules.
    always_comb begin
        code        = ERR_NONE;
        phase_nxt   = phase_q;
        kick_hi_nxt = kick_hi_q;
        kick_c      = 1'b0;
        done_c      = 1'b0;
        case (phase_q)
            PH_RESYNC: begin
                if (valid && (n == '0)) phase_nxt = PH_IDLE;
            end
            PH_FLASH: begin
                if (!valid)         code = ERR_THERMO;
                else if (n != '0)   code = ERR_REVERSE;
                else begin
                    phase_nxt = PH_IDLE;
                    done_c    = 1'b1;
                end
            end
            default: begin
                if (!valid) begin
                    code = ERR_THERMO;
                end else if ((phase_q == PH_DN3) && (p_q == '0) && (led == ALL_ON)) begin
                    phase_nxt = PH_FLASH;
                end else if (big) begin
                    code = (led == ALL_ON) ? ERR_THERMO : ERR_STEP;
                end else if (!hold) begin
                    case (phase_q)
                        PH_IDLE: if (up) phase_nxt = PH_UP1;
                        PH_UP1: begin
                            if (up) begin
                                if (n > LIM_UP1) code = ERR_OVERSHOOT;
                            end else if (p_q == LIM_UP1) phase_nxt = PH_DN1;
                            else code = ERR_REVERSE;
                        end
                        PH_DN1: begin
                            if (up) begin
                                if (p_q == '0) phase_nxt = PH_UP2;
                                else code = ERR_REVERSE;
                            end
                        end
                        PH_UP2: begin
                            if (up) begin
                                if (n > LIM_UP2) code = ERR_OVERSHOOT;
                            end else if (p_q == LIM_UP2) phase_nxt = PH_DN2;
                            else if (kick_ok) begin
                                phase_nxt = PH_KICK2;
                                kick_c    = 1'b1;
                            end else code = ERR_REVERSE;
                        end
                        PH_KICK2: begin
                            if (up) begin
                                if (p_q == '0) phase_nxt = PH_UP2;
                                else code = ERR_REVERSE;
                            end
                        end
                        PH_DN2: begin
                            if (up) begin
                                if (p_q == LIM_DN2) phase_nxt = PH_UP3;
                                else code = ERR_REVERSE;
                            end else if (n < LIM_DN2) code = ERR_OVERSHOOT;
                        end
                        PH_UP3: begin
                            if (dn) begin
                                if (p_q == LIM_UP3) phase_nxt = PH_DN3;
                                else if (kick_ok) begin
                                    phase_nxt   = PH_KICK3;
                                    kick_c      = 1'b1;
                                    kick_hi_nxt = (p_q == KICK_HI);
                                end else code = ERR_REVERSE;
                            end
                        end
                        PH_KICK3: begin
                            if (up) begin
                                if ((kick_hi_q && (p_q == KICK_LO)) ||
                                    (!kick_hi_q && (p_q == KICK_LO - CNT_W'(1))))
                                    phase_nxt = PH_UP3;
                                else code = ERR_REVERSE;
                            end
                        end
                        PH_DN3: if (up) code = ERR_REVERSE;
                        default: ;
                    endcase
                end
            end
        endcase
        if ((code == ERR_NONE) && (phase_q != PH_RESYNC) && stall_hit) code = ERR_STALL;
        if (code != ERR_NONE) begin
            phase_nxt = PH_RESYNC;
            kick_c    = 1'b0;
            done_c    = 1'b0;
        end
    end

    // Phase, history and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q    <= PH_IDLE;
            p_q        <= '0;
            flick_q    <= 1'b0;
            kick_hi_q  <= 1'b0;
            kick_pulse <= 1'b0;
            done_pulse <= 1'b0;
            error      <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            phase_q    <= phase_nxt;
            p_q        <= n;
            flick_q    <= flick;
            kick_hi_q  <= kick_hi_nxt;
            kick_pulse <= kick_c;
            done_pulse <= done_c;
            if ((code != ERR_NONE) && !error) begin
                error    <= 1'b1;
                err_code <= code;
            end
        end
    end

    assign phase     = phase_q;
    assign lit_count = p_q;

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// Directed self-checking bench for bound_flasher_monitor.
module tb_bound_flasher_monitor;

`ifdef BFM_STALL_CHECK_EN
    localparam int unsigned TB_STALL_MAX = 4;
`else
    localparam int unsigned TB_STALL_MAX = 64;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] led = '0;
    logic        flick = 1'b0;
    logic [3:0]  phase;
    logic [4:0]  lit_count;
    logic        kick_pulse;
    logic        done_pulse;
    logic        error;
    logic [2:0]  err_code;

    int checks = 0;
    int errors = 0;

    bound_flasher_monitor #(.STALL_MAX(TB_STALL_MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .led        (led),
        .flick      (flick),
        .phase      (phase),
        .lit_count  (lit_count),
        .kick_pulse (kick_pulse),
        .done_pulse (done_pulse),
        .error      (error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] th(input int k);
        logic [31:0] v;
        v = (32'd1 << k) - 32'd1;
        return v[15:0];
    endfunction

    task automatic step(input logic [15:0] l, input logic f);
        led   = l;
        flick = f;
        @(posedge clk);
        #1;
    endtask

    task automatic ramp(input int from, input int to);
        if (from <= to) for (int i = from; i <= to; i++) step(th(i), 1'b0);
        else            for (int i = from; i >= to; i--) step(th(i), 1'b0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_phase"}, 32'(phase), 32'd0);
        chk({tag, "_lit"},   32'(lit_count), 32'd0);
        chk({tag, "_kick"},  32'(kick_pulse), 32'd0);
        chk({tag, "_done"},  32'(done_pulse), 32'd0);
        chk({tag, "_err"},   32'(error), 32'd0);
        chk({tag, "_code"},  32'(err_code), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(16'h0000, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        step(16'h0000, 1'b0);
        step(16'h0000, 1'b0);
        chk_reset_vals("rst0");
        reset = 1'b0;

        // Clean full sequence
        step(16'h0000, 1'b0);        chk("idle", 32'(phase), 32'd0);
        step(th(1), 1'b0);           chk("up1", 32'(phase), 32'd1);
        ramp(2, 6);                  chk("up1_top", 32'(lit_count), 32'd6);
        step(th(5), 1'b0);           chk("dn1", 32'(phase), 32'd2);
        ramp(4, 0);                  chk("dn1_low", 32'(phase), 32'd2);
        step(th(1), 1'b0);           chk("up2", 32'(phase), 32'd3);
        ramp(2, 11);
        step(th(10), 1'b0);          chk("dn2", 32'(phase), 32'd4);
        chk("dn2_lit", 32'(lit_count), 32'd10);
        ramp(9, 5);
        step(th(6), 1'b0);           chk("up3", 32'(phase), 32'd5);
        ramp(7, 16);                 chk("up3_top", 32'(lit_count), 32'd16);
        chk("up3_top_ph", 32'(phase), 32'd5);
        step(th(15), 1'b0);          chk("dn3", 32'(phase), 32'd6);
        ramp(14, 0);
        step(16'hFFFF, 1'b0);        chk("flash", 32'(phase), 32'd7);
        chk("flash_lit", 32'(lit_count), 32'd16);
        step(16'h0000, 1'b0);        chk("done_ph", 32'(phase), 32'd0);
        chk("done_p", 32'(done_pulse), 32'd1);
        chk("done_nokick", 32'(kick_pulse), 32'd0);
        step(16'h0000, 1'b0);        chk("done_once", 32'(done_pulse), 32'd0);
        chk("clean_err", 32'(error), 32'd0);

        // Kick-back in UP2 from 10
        step(th(1), 1'b0);
        ramp(2, 6);
        ramp(5, 0);
        step(th(1), 1'b0);           chk("k_up2", 32'(phase), 32'd3);
        ramp(2, 9);
        step(th(10), 1'b1);
        step(th(9), 1'b0);           chk("kick_p", 32'(kick_pulse), 32'd1);
        chk("kick2_ph", 32'(phase), 32'd8);
        chk("kick_err", 32'(error), 32'd0);
        step(th(8), 1'b0);           chk("kick_once", 32'(kick_pulse), 32'd0);
        ramp(7, 0);
        step(th(1), 1'b0);           chk("kick_ret", 32'(phase), 32'd3);

        // Unflicked drop in UP3
        ramp(2, 11);
        step(th(10), 1'b0);
        ramp(9, 5);
        step(th(6), 1'b0);           chk("u3_ph", 32'(phase), 32'd5);
        ramp(7, 10);
        step(th(9), 1'b0);           chk("rev_err", 32'(error), 32'd1);
        chk("rev_code", 32'(err_code), 32'd3);
        chk("rev_ph", 32'(phase), 32'd15);
        chk("rev_nokick", 32'(kick_pulse), 32'd0);
        step(16'h0000, 1'b0);        chk("resync_idle", 32'(phase), 32'd0);

        // Non-thermometer value, then a later step error keeps the first code
        do_reset();                  chk("rst1_err", 32'(error), 32'd0);
        step(th(1), 1'b0);
        step(th(2), 1'b0);
        step(16'h0005, 1'b0);        chk("thermo_code", 32'(err_code), 32'd1);
        chk("thermo_ph", 32'(phase), 32'd15);
        step(16'h0000, 1'b0);
        step(th(1), 1'b0);
        step(th(2), 1'b0);           chk("re_up1", 32'(phase), 32'd1);
        step(th(4), 1'b0);           chk("step_ph", 32'(phase), 32'd15);
        chk("sticky_code", 32'(err_code), 32'd1);
        chk("sticky_err", 32'(error), 32'd1);

        // All-on outside the flash slot
        do_reset();
        step(16'hFFFF, 1'b0);        chk("allon_code", 32'(err_code), 32'd1);
        chk("allon_ph", 32'(phase), 32'd15);

        // Reset during DN2 at count 8
        do_reset();
        step(16'h0000, 1'b0);
        step(th(1), 1'b0);
        ramp(2, 6);
        ramp(5, 0);
        step(th(1), 1'b0);
        ramp(2, 11);
        ramp(10, 8);                 chk("pre_rst_ph", 32'(phase), 32'd4);
        chk("pre_rst_lit", 32'(lit_count), 32'd8);
        reset = 1'b1;
        step(th(7), 1'b1);
        chk_reset_vals("rst2");
        reset = 1'b0;
        step(16'h0000, 1'b0);        chk("post_idle", 32'(phase), 32'd0);
        step(th(1), 1'b0);           chk("post_up1", 32'(phase), 32'd1);
        chk("post_lit", 32'(lit_count), 32'd1);
        step(th(2), 1'b0);           chk("post_err", 32'(error), 32'd0);

`ifdef BFM_STALL_CHECK_EN
        // Stall detection on a held non-zero value
        do_reset();
        step(16'h0000, 1'b0);
        step(th(1), 1'b0);
        ramp(2, 6);
        ramp(5, 0);
        step(th(1), 1'b0);
        ramp(2, 7);
        step(th(7), 1'b0);
        step(th(7), 1'b0);
        step(th(7), 1'b0);           chk("stall_pre", 32'(error), 32'd0);
        step(th(7), 1'b0);           chk("stall_code", 32'(err_code), 32'd5);
        chk("stall_ph", 32'(phase), 32'd15);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
